// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared sequencer state encodings, datapath modes and accumulator sizing
package bnn_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_DRAIN  = 3'd2,
      S_DECIDE = 3'd3,
      S_DONE   = 3'd4
   } seq_state_t;

   localparam logic [2:0] XP_MODE_FULL = 3'b011;
   localparam logic [2:0] XP_MODE_IDLE = 3'b000;

   // 7-bit popcounts summed over n_word words can never exceed 7+log2(n_word) bits
   function automatic int acc_w(input int n_word);
      return 7 + $clog2(n_word);
   endfunction

endpackage

// File: rtl/bnn_seq_acc.sv
// rtl/bnn_seq_acc.sv - per-neuron popcount accumulator and returned-result counter
module bnn_seq_acc #(
   parameter int N_WORD = 4,
   parameter int ACC_W  = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             pop_valid,
   input  logic [6:0]       pop,
   output logic [ACC_W-1:0] acc,
   output logic             full
);

   localparam int CW = $clog2(N_WORD) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(N_WORD);

   logic [CW-1:0] count;
   logic          take;

   assign take = en && pop_valid;
   assign full = (count == CNT_FULL);

   // clr arrives in the first issue cycle, which may already carry a zero-latency result
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         count <= '0;
      end else if (clr) begin
         acc   <= take ? ACC_W'(pop) : '0;
         count <= take ? CW'(1) : '0;
      end else if (take) begin
         acc   <= acc + ACC_W'(pop);
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/bnn_xnor_seq.sv
// rtl/bnn_xnor_seq.sv - binarised-layer sequencer: issues xnor-popcount words, thresholds neurons
// Optional raw score output enabled by defining BNN_SEQ_SCORE_EN.
module bnn_xnor_seq
   import bnn_pkg::*;
#(
   parameter int N_NEURON = 32,
   parameter int N_WORD   = 4,
   parameter int AW       = 9,
   localparam int ACC_W   = acc_w(N_WORD)
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic                iSTART,
   input  logic [ACC_W-1:0]    iTHRESH,
   output logic [AW-1:0]       oWADDR,
   output logic                oXP_EN,
   output logic [2:0]          oXP_STATE,
   input  logic [6:0]          iPOP,
   input  logic                iPOP_VALID,
   output logic                oBUSY,
   output logic [N_NEURON-1:0] oRESULT,
   output logic                oDONE,
   output logic [ACC_W-1:0]    oSCORE,
   output logic                oSCORE_VALID
);

   localparam int NW = $clog2(N_NEURON);
   localparam int WW = (N_WORD > 1) ? $clog2(N_WORD) : 1;
   localparam logic [NW-1:0] LAST_N = NW'(N_NEURON - 1);
   localparam logic [WW-1:0] LAST_W = WW'(N_WORD - 1);

   seq_state_t       state;
   logic [NW-1:0]    neuron;
   logic [WW-1:0]    word;
   logic [ACC_W-1:0] thresh;
   logic [ACC_W-1:0] acc;
   logic             acc_full;
   logic             acc_clr;
   logic             count_en;

   assign count_en = (state == S_ISSUE) || (state == S_DRAIN);

   bnn_seq_acc #(.N_WORD(N_WORD), .ACC_W(ACC_W)) u_acc (
      .clk       (iCLK),
      .rst       (iRST),
      .clr       (acc_clr),
      .en        (count_en),
      .pop_valid (iPOP_VALID),
      .pop       (iPOP),
      .acc       (acc),
      .full      (acc_full)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= S_IDLE;
         neuron    <= '0;
         word      <= '0;
         thresh    <= '0;
         acc_clr   <= 1'b0;
         oWADDR    <= '0;
         oXP_EN    <= 1'b0;
         oXP_STATE <= XP_MODE_IDLE;
         oBUSY     <= 1'b0;
         oRESULT   <= '0;
         oDONE     <= 1'b0;
      end else begin
         acc_clr <= 1'b0;
         oDONE   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (iSTART) begin
                  state     <= S_ISSUE;
                  thresh    <= iTHRESH;
                  oRESULT   <= '0;
                  neuron    <= '0;
                  word      <= '0;
                  oWADDR    <= '0;
                  oXP_EN    <= 1'b1;
                  oXP_STATE <= XP_MODE_FULL;
                  oBUSY     <= 1'b1;
                  acc_clr   <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (word == LAST_W) begin
                  state  <= S_DRAIN;
                  oXP_EN <= 1'b0;
               end else begin
                  word   <= word + WW'(1);
                  oWADDR <= oWADDR + AW'(1);
               end
            end
            // the decision lands on entry so oRESULT is already updated during DECIDE
            S_DRAIN: begin
               if (acc_full) begin
                  state           <= S_DECIDE;
                  oRESULT[neuron] <= (acc >= thresh);
               end
            end
            S_DECIDE: begin
               if (neuron == LAST_N) begin
                  state     <= S_DONE;
                  oDONE     <= 1'b1;
                  oBUSY     <= 1'b0;
                  oXP_STATE <= XP_MODE_IDLE;
               end else begin
                  state   <= S_ISSUE;
                  neuron  <= neuron + NW'(1);
                  word    <= '0;
                  oWADDR  <= oWADDR + AW'(1);
                  oXP_EN  <= 1'b1;
                  acc_clr <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef BNN_SEQ_SCORE_EN
   wire decide_go = (state == S_DRAIN) && acc_full;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oSCORE       <= '0;
         oSCORE_VALID <= 1'b0;
      end else begin
         oSCORE_VALID <= decide_go;
         if (decide_go) oSCORE <= acc;
      end
   end
`else
   assign oSCORE       = '0;
   assign oSCORE_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_xnor_seq.sv
// tb/tb_bnn_xnor_seq.sv - directed scoreboard bench for bnn_xnor_seq (N_NEURON=2, N_WORD=4)
// Score expectations follow BNN_SEQ_SCORE_EN as defined for the build.
module tb_bnn_xnor_seq;

   localparam int NN = 2;
   localparam int NWD = 4;
   localparam int AW = 9;
   localparam int ACC_W = 9;

   logic            iCLK = 1'b0;
   logic            iRST = 1'b1;
   logic            iSTART = 1'b0;
   logic [ACC_W-1:0] iTHRESH = '0;
   logic [AW-1:0]   oWADDR;
   logic            oXP_EN;
   logic [2:0]      oXP_STATE;
   logic [6:0]      iPOP = '0;
   logic            iPOP_VALID = 1'b0;
   logic            oBUSY;
   logic [NN-1:0]   oRESULT;
   logic            oDONE;
   logic [ACC_W-1:0] oSCORE;
   logic            oSCORE_VALID;

   bnn_xnor_seq #(.N_NEURON(NN), .N_WORD(NWD), .AW(AW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iTHRESH(iTHRESH),
      .oWADDR(oWADDR), .oXP_EN(oXP_EN), .oXP_STATE(oXP_STATE),
      .iPOP(iPOP), .iPOP_VALID(iPOP_VALID), .oBUSY(oBUSY), .oRESULT(oRESULT),
      .oDONE(oDONE), .oSCORE(oSCORE), .oSCORE_VALID(oSCORE_VALID)
   );

   always #5 iCLK = ~iCLK;

   int checks = 0;
   int errors = 0;
   int lat = 0;
   logic inject_v = 1'b0;
   logic [6:0] pop_mem [0:511];
   logic       vp [0:3] = '{default: 1'b0};
   logic [6:0] pp [0:3] = '{default: 7'd0};
   logic [NN-1:0] exp_q [$];

   int done_cnt, busy_cnt, sv_cnt, xs_bad, addr_bad, en_n;
   logic [ACC_W-1:0] first_score;
   logic [NN-1:0]    res_at_done;

   // datapath model: returns pop_mem[addr] lat cycles after each issue strobe
   always begin
      @(posedge iCLK);
      #1;
      for (int i = 3; i > 0; i--) begin
         vp[i] = vp[i-1];
         pp[i] = pp[i-1];
      end
      vp[0] = (oXP_EN === 1'b1);
      pp[0] = pop_mem[oWADDR];
      iPOP_VALID = vp[lat] | inject_v;
      iPOP = inject_v ? 7'd99 : pp[lat];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge iCLK);
      #2;
   endtask

   task automatic load(input logic [6:0] a0, a1, a2, a3, b0, b1, b2, b3);
      pop_mem[0] = a0; pop_mem[1] = a1; pop_mem[2] = a2; pop_mem[3] = a3;
      pop_mem[4] = b0; pop_mem[5] = b1; pop_mem[6] = b2; pop_mem[7] = b3;
   endtask

   task automatic run_pass(input string tag, input logic [ACC_W-1:0] th, input int lt,
                           input logic [NN-1:0] exp, input logic [ACC_W-1:0] exp_s0,
                           input bit repulse);
      lat = lt;
      exp_q.push_back(exp);
      iTHRESH = th;
      iSTART = 1'b1;
      step();
      iSTART = 1'b0;
      iTHRESH = '0;
      done_cnt = 0; busy_cnt = 0; sv_cnt = 0; xs_bad = 0; addr_bad = 0; en_n = 0;
      first_score = '0;
      res_at_done = '0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (oXP_EN) begin
            if (oWADDR !== AW'(en_n)) addr_bad++;
            en_n++;
         end
         if (oBUSY) busy_cnt++;
         if (oXP_STATE !== (oBUSY ? 3'b011 : 3'b000)) xs_bad++;
         if (oSCORE_VALID) begin
            if (sv_cnt == 0) first_score = oSCORE;
            sv_cnt++;
         end
         if (oDONE) begin
            done_cnt++;
            res_at_done = oRESULT;
         end
         iSTART = repulse && (en_n == 2 || en_n == 6);
         step();
      end
      iSTART = 1'b0;
      chk({tag, "_done_once"}, done_cnt, 1);
      if (done_cnt > 0 && exp_q.size() > 0) chk({tag, "_result"}, res_at_done, exp_q.pop_front());
      chk({tag, "_result_hold"}, oRESULT, exp);
      chk({tag, "_issue_count"}, en_n, NN * NWD);
      chk({tag, "_addr_seq_bad"}, addr_bad, 0);
      chk({tag, "_xp_state_bad"}, xs_bad, 0);
      chk({tag, "_busy_cycles"}, busy_cnt, NN * (NWD + 2 + lt));
      chk({tag, "_waddr_hold"}, oWADDR, NN * NWD - 1);
`ifdef BNN_SEQ_SCORE_EN
      chk({tag, "_score0"}, first_score, exp_s0);
      chk({tag, "_score_valid_cnt"}, sv_cnt, NN);
`else
      chk({tag, "_score_valid_cnt"}, sv_cnt, 0);
      chk({tag, "_score_zero"}, oSCORE, 0);
      if (exp_s0 === 'x) chk({tag, "_score_arg"}, 0, 1);
`endif
   endtask

   initial begin
      bit found;
      int late_done;

      for (int i = 0; i < 512; i++) pop_mem[i] = 7'd0;
      iRST = 1'b1;
      repeat (2) @(posedge iCLK);
      #2;
      iRST = 1'b0;
      chk("rst_busy", oBUSY, 0);
      chk("rst_xp_en", oXP_EN, 0);
      chk("rst_xp_state", oXP_STATE, 0);
      chk("rst_waddr", oWADDR, 0);
      chk("rst_result", oRESULT, 0);
      chk("rst_done", oDONE, 0);
      chk("rst_score", oSCORE, 0);
      chk("rst_score_valid", oSCORE_VALID, 0);

      load(50, 50, 50, 50, 60, 40, 50, 49);
      run_pass("basic", 200, 2, 2'b01, 200, 0);

      load(112, 112, 112, 111, 112, 112, 112, 112);
      run_pass("bound", 448, 1, 2'b10, 447, 0);

      inject_v = 1'b1;
      step();
      inject_v = 1'b0;
      repeat (3) step();
      chk("idle_pop_result", oRESULT, 2'b10);
      chk("idle_pop_busy", oBUSY, 0);
      chk("idle_pop_xp_en", oXP_EN, 0);

      load(10, 20, 30, 40, 1, 2, 3, 4);
      run_pass("zero_lat", 10, 0, 2'b11, 100, 0);

      load(50, 50, 50, 50, 60, 40, 50, 49);
      lat = 2;
      iTHRESH = 200;
      iSTART = 1'b1;
      step();
      iSTART = 1'b0;
      en_n = 0;
      found = 1'b0;
      for (int cyc = 0; cyc < 60 && !found; cyc++) begin
         if (oXP_EN) en_n++;
         else if (en_n == NN * NWD) found = 1'b1;
         if (!found) step();
      end
      chk("abort_drain_reached", found, 1);
      iRST = 1'b1;
      step();
      iRST = 1'b0;
      chk("abort_busy", oBUSY, 0);
      chk("abort_xp_en", oXP_EN, 0);
      chk("abort_xp_state", oXP_STATE, 0);
      chk("abort_waddr", oWADDR, 0);
      chk("abort_result", oRESULT, 0);
      chk("abort_score", oSCORE, 0);
      late_done = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (oDONE !== 1'b0 || oBUSY !== 1'b0) late_done++;
         step();
      end
      chk("abort_no_done", late_done, 0);
      chk("abort_result_after", oRESULT, 0);

      run_pass("after_abort", 200, 2, 2'b01, 200, 0);
      run_pass("restart_ignored", 200, 2, 2'b01, 200, 1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bnn_xnor_seq.md
BNN_XNOR_SEQ -- requirements
Module: bnn_xnor_seq

Interface
REQ-001 SHALL have parameter N_NEURON, default 32, number of output neurons per layer pass (2..64).
REQ-002 SHALL have parameter N_WORD, default 4, number of weight words per neuron (1..16, power of 2).
REQ-003 SHALL have parameter AW, default 9, bit width of oWADDR.
REQ-004 SHALL have port iCLK, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port iRST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port iSTART, input, 1 bit: single-cycle pulse that starts a layer pass.
REQ-007 SHALL have port iTHRESH, input, ACC_W bits: per-layer firing threshold, sampled on an accepted iSTART.
REQ-008 SHALL have port oWADDR, output, AW bits: weight/activation word address driven to memories and datapath.
REQ-009 SHALL have port oXP_EN, output, 1 bit: issue strobe to the xnor-popcount datapath.
REQ-010 SHALL have port oXP_STATE, output, 3 bits: datapath mode; held at 3'b011 (full-word mode) while busy, 3'b000 otherwise.
REQ-011 SHALL have port iPOP, input, 7 bits: popcount result returned by the datapath.
REQ-012 SHALL have port iPOP_VALID, input, 1 bit: qualifies iPOP; results return in issue order.
REQ-013 SHALL have port oBUSY, output, 1 bit: high from the cycle after an accepted iSTART until oDONE.
REQ-014 SHALL have port oRESULT, output, N_NEURON bits: binarised neuron outputs, bit n for neuron n.
REQ-015 SHALL have port oDONE, output, 1 bit: single-cycle pulse when oRESULT is complete.
REQ-016 SHALL have port oSCORE, output, ACC_W bits: raw accumulated score of the last decided neuron.
REQ-017 SHALL have port oSCORE_VALID, output, 1 bit: qualifies oSCORE.

Function
REQ-018 SHALL define ACC_W = 7 + log2(N_WORD); the accumulator SHALL never overflow.
REQ-019 SHALL implement the FSM states IDLE, ISSUE, DRAIN, DECIDE and DONE.
REQ-020 SHALL move IDLE->ISSUE on iSTART; iSTART in any other state SHALL be ignored.
REQ-021 In ISSUE, SHALL assert oXP_EN for exactly N_WORD consecutive cycles per neuron, with oWADDR = neuron*N_WORD + word.
REQ-022 SHALL move ISSUE->DRAIN after the last word is issued; DRAIN SHALL wait until N_WORD iPOP_VALIDs for the neuron have been counted.
REQ-023 SHALL count iPOP_VALID in both ISSUE and DRAIN; iPOP_VALID in IDLE, DECIDE or DONE SHALL be ignored.
REQ-024 SHALL clear the accumulator on entry to ISSUE and add iPOP on each counted iPOP_VALID.
REQ-025 In DECIDE (1 cycle), SHALL set oRESULT[neuron] = (acc >= threshold) unsigned; equality fires.
REQ-026 From DECIDE, SHALL go to ISSUE for the next neuron, or to DONE after neuron N_NEURON-1.
REQ-027 DONE SHALL last 1 cycle, pulse oDONE and return to IDLE; oRESULT SHALL hold until the next accepted iSTART clears it.
REQ-028 SHALL keep oWADDR at its last value while oXP_EN is low.

Reset
REQ-029 On iRST, SHALL go to IDLE and zero oWADDR, oXP_EN, oXP_STATE, oBUSY, oRESULT, oDONE, oSCORE, oSCORE_VALID, the counters and the accumulator.
REQ-030 iRST mid-pass SHALL abort the pass with no oDONE; results still in flight SHALL be discarded.
REQ-031 iRST SHALL take priority over a simultaneous iSTART.

Configuration
REQ-032 When BNN_SEQ_SCORE_EN is defined, SHALL drive oSCORE = acc and pulse oSCORE_VALID in each DECIDE cycle.
REQ-033 When BNN_SEQ_SCORE_EN is undefined, SHALL tie oSCORE and oSCORE_VALID to 0 and instantiate no score register.

Structure
REQ-034 SHALL place the FSM state encodings, the XP_MODE_FULL (3'b011) and XP_MODE_IDLE constants, and the ACC_W function in shared package bnn_pkg.
REQ-035 SHALL contain one sub-module, bnn_seq_acc (accumulator plus return counter); the FSM and address generation stay in the top level.

Verification
REQ-036 Scenario: N_NEURON=2, N_WORD=4, iTHRESH=200, pops 50,50,50,50 then 60,40,50,49, 2-cycle datapath latency -> oRESULT=2'b01, oDONE once, oWADDR sequence 0..7.
REQ-037 Scenario: threshold boundary, pops summing to exactly iTHRESH=448 (112x4) -> bit=1; summing to 447 -> bit=0; no accumulator overflow at maximum 448.
REQ-038 Scenario: iRST asserted in DRAIN of neuron 1 -> next cycle IDLE, all outputs 0, no oDONE; a fresh iSTART completes normally.
REQ-039 Scenario: iSTART re-pulsed mid-pass and iPOP_VALID pulsed in IDLE -> no effect on the FSM, counts or oRESULT.
REQ-040 Scenario: BNN_SEQ_SCORE_EN defined, pops 10,20,30,40 -> oSCORE=100 with oSCORE_VALID for 1 cycle; undefined -> both stay 0.
REQ-041 Scenario: zero-latency datapath (iPOP_VALID in the same cycle as oXP_EN) -> DRAIN lasts 1 cycle and results are correct.
